// File: rtl/exu_hazard_ctrl.sv
// Execute-stage hazard control: tracks the EX/MEM in-flight slots and derives the
// stall, the operand forwarding selects and the misprediction flush.

module exu_hazard_src #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_used,
  input  logic              i_ex_v,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_wen,
  input  logic              i_ex_ld,
  input  logic              i_mem_v,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_wen,
  input  logic              i_mem_ld,
  input  logic              i_lsu_resp,
  output logic [1:0]        o_fwd,
  output logic              o_luh
);
  logic w_src_ok, w_ex_m, w_mem_m;

  // x0 is hardwired zero, so it never depends on a producer
  assign w_src_ok = i_used & (i_src != '0);
  assign w_ex_m   = w_src_ok & i_ex_v  & i_ex_wen  & (i_ex_rd  == i_src);
  assign w_mem_m  = w_src_ok & i_mem_v & i_mem_wen & (i_mem_rd == i_src);

  always_comb begin
    o_fwd = 2'b00;
    if (w_ex_m && !i_ex_ld)                       o_fwd = 2'b01;
    else if (w_mem_m && (!i_mem_ld || i_lsu_resp)) o_fwd = 2'b10;
  end

  assign o_luh = (w_ex_m & i_ex_ld) | (w_mem_m & i_mem_ld & ~i_lsu_resp);
endmodule

module exu_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              decode_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_wen,
  input  logic              id_is_load,
  input  logic              lsu_resp_valid,
  input  logic              is_wrong_prediction,
  output logic              block,
  output logic              clear_pipeline,
  output logic [1:0]        op1_fwd,
  output logic [1:0]        op2_fwd,
  output logic [15:0]       hazard_stall_cnt
);
  typedef enum logic [1:0] {RUN, LOAD_WAIT, FLUSH} state_t;

  localparam logic [3:0] FC_M1 = 4'(FLUSH_CYCLES - 1);

  state_t            r_state;
  logic [3:0]        r_fcnt;
  logic              r_clear;
  logic              r_ex_v, r_ex_wen, r_ex_ld;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_mem_v, r_mem_wen, r_mem_ld;
  logic [REG_AW-1:0] r_mem_rd;
  logic [15:0]       r_stall_cnt;

  logic [1:0][REG_AW-1:0] w_src;
  logic [1:0]             w_used;
  logic [1:0][1:0]        w_fwd;
  logic [1:0]             w_luh;
  logic                   w_hazard, w_block, w_mem_retire;

  assign w_src  = {id_rs2, id_rs1};
  assign w_used = {id_rs2_used, id_rs1_used};

  for (genvar g = 0; g < 2; g++) begin : g_src
    exu_hazard_src #(.REG_AW(REG_AW)) u_src (
      .i_src      (w_src[g]),
      .i_used     (w_used[g]),
      .i_ex_v     (r_ex_v),
      .i_ex_rd    (r_ex_rd),
      .i_ex_wen   (r_ex_wen),
      .i_ex_ld    (r_ex_ld),
      .i_mem_v    (r_mem_v),
      .i_mem_rd   (r_mem_rd),
      .i_mem_wen  (r_mem_wen),
      .i_mem_ld   (r_mem_ld),
      .i_lsu_resp (lsu_resp_valid),
      .o_fwd      (w_fwd[g]),
      .o_luh      (w_luh[g])
    );
  end

  assign w_hazard = |w_luh;
  // Misprediction outranks the stall; a flush never stalls
  assign w_block  = w_hazard & ~is_wrong_prediction & (r_state != FLUSH);
  // While stalled, MEM may still drain unless it is a load awaiting data
  assign w_mem_retire = ~r_mem_v | ~r_mem_ld | lsu_resp_valid;

  assign block            = w_block;
  assign clear_pipeline   = r_clear;
  assign op1_fwd          = w_fwd[0];
  assign op2_fwd          = w_fwd[1];
  assign hazard_stall_cnt = r_stall_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_fcnt    <= '0;
      r_clear   <= 1'b0;
      r_ex_v    <= 1'b0;
      r_ex_rd   <= '0;
      r_ex_wen  <= 1'b0;
      r_ex_ld   <= 1'b0;
      r_mem_v   <= 1'b0;
      r_mem_rd  <= '0;
      r_mem_wen <= 1'b0;
      r_mem_ld  <= 1'b0;
    end else if (is_wrong_prediction) begin
      r_state <= FLUSH;
      r_fcnt  <= FC_M1;
      r_clear <= 1'b1;
      r_ex_v  <= 1'b0;
      r_mem_v <= 1'b0;
    end else begin
      case (r_state)
        FLUSH: begin
          if (r_fcnt == '0) begin
            r_state <= RUN;
            r_clear <= 1'b0;
          end else begin
            r_fcnt <= r_fcnt - 4'd1;
          end
        end
        default: begin
          r_state <= w_hazard ? LOAD_WAIT : RUN;
          if (!w_block || w_mem_retire) begin
            r_mem_v   <= r_ex_v;
            r_mem_rd  <= r_ex_rd;
            r_mem_wen <= r_ex_wen;
            r_mem_ld  <= r_ex_ld;
          end
          if (!w_block) begin
            r_ex_v   <= decode_valid;
            r_ex_rd  <= id_rd;
            r_ex_wen <= id_rd_wen;
            r_ex_ld  <= id_is_load;
          end else if (w_mem_retire) begin
            r_ex_v <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                              r_stall_cnt <= '0;
    else if (w_block && r_stall_cnt != '1)   r_stall_cnt <= r_stall_cnt + 16'd1;
  end
endmodule

// File: tb/tb_exu_hazard_ctrl.sv
// Directed scenarios plus a randomized run against a slot-list reference model.
module tb_exu_hazard_ctrl;
  localparam int FC = 2;

  logic       clock = 1'b0, reset = 1'b0;
  logic       decode_valid, id_rs1_used, id_rs2_used, id_rd_wen, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       lsu_resp_valid, is_wrong_prediction;
  logic       block, clear_pipeline;
  logic [1:0] op1_fwd, op2_fwd;
  logic [15:0] hazard_stall_cnt;

  int checks = 0, errors = 0;

  exu_hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset(reset), .decode_valid(decode_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_is_load(id_is_load),
    .lsu_resp_valid(lsu_resp_valid), .is_wrong_prediction(is_wrong_prediction),
    .block(block), .clear_pipeline(clear_pipeline), .op1_fwd(op1_fwd), .op2_fwd(op2_fwd),
    .hazard_stall_cnt(hazard_stall_cnt)
  );

  always #5 clock = ~clock;

  // Reference model: list of in-flight producers, index 0 = youngest (EX)
  typedef struct { bit v; int rd; bit wen; bit ld; } slot_t;
  slot_t m_slot[2];
  int    m_flush, m_stall;

  function automatic bit m_match(int s, int src, bit used);
    return used && src != 0 && m_slot[s].v && m_slot[s].wen && m_slot[s].rd == src;
  endfunction

  function automatic logic [1:0] m_fwd(int src, bit used);
    if (m_match(0, src, used) && !m_slot[0].ld) return 2'b01;
    if (m_match(1, src, used) && (!m_slot[1].ld || lsu_resp_valid)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit m_hazard();
    bit h = 0;
    for (int k = 0; k < 2; k++) begin
      int s  = (k == 0) ? int'(id_rs1) : int'(id_rs2);
      bit u  = (k == 0) ? id_rs1_used : id_rs2_used;
      h |= m_match(0, s, u) && m_slot[0].ld;
      h |= m_match(1, s, u) && m_slot[1].ld && !lsu_resp_valid;
    end
    return h;
  endfunction

  function automatic bit m_block();
    return m_flush == 0 && !is_wrong_prediction && m_hazard();
  endfunction

  task automatic model_reset();
    m_slot[0] = '{0, 0, 0, 0};
    m_slot[1] = '{0, 0, 0, 0};
    m_flush = 0;
    m_stall = 0;
  endtask

  task automatic model_step();
    bit blk = m_block();
    if (blk && m_stall < 65535) m_stall++;
    if (is_wrong_prediction) begin
      m_flush = FC;
      m_slot[0].v = 0;
      m_slot[1].v = 0;
    end else if (m_flush > 0) begin
      m_flush--;
    end else if (!blk) begin
      m_slot[1] = m_slot[0];
      m_slot[0] = '{decode_valid, int'(id_rd), id_rd_wen, id_is_load};
    end else if (!m_slot[1].v || !m_slot[1].ld || lsu_resp_valid) begin
      m_slot[1] = m_slot[0];
      m_slot[0].v = 0;
    end
  endtask

  task automatic drive(bit dv, int rs1, bit u1, int rs2, bit u2, int rd, bit wen, bit ld,
                       bit resp, bit wp);
    decode_valid = dv; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2); id_rs2_used = u2;
    id_rd = 5'(rd); id_rd_wen = wen; id_is_load = ld;
    lsu_resp_valid = resp; is_wrong_prediction = wp;
  endtask

  task automatic idle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  task automatic next_cycle(); @(posedge clock); #1; endtask

  task automatic do_reset();
    idle();
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    model_reset();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #3;
    checks += 5;
    if (block !== 1'b0) begin errors++; $display("FAIL reset_block got %b want 0", block); end
    if (clear_pipeline !== 1'b0) begin errors++; $display("FAIL reset_clear got %b want 0", clear_pipeline); end
    if (op1_fwd !== 2'b00) begin errors++; $display("FAIL reset_op1 got %b want 00", op1_fwd); end
    if (op2_fwd !== 2'b00) begin errors++; $display("FAIL reset_op2 got %b want 00", op2_fwd); end
    if (hazard_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", hazard_stall_cnt); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); // add x5,x1,x2
    next_cycle();
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0); // sub x6,x5,x1
    @(negedge clock);
    checks += 3;
    if (op1_fwd !== 2'b01) begin errors++; $display("FAIL b2b_op1 got %b want 01", op1_fwd); end
    if (op2_fwd !== 2'b00) begin errors++; $display("FAIL b2b_op2 got %b want 00", op2_fwd); end
    if (block !== 1'b0) begin errors++; $display("FAIL b2b_block got %b want 0", block); end
    next_cycle();
  endtask

  task automatic test_distance2();
    do_reset();
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); // add x5
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // nop
    next_cycle();
    drive(1, 2, 1, 5, 1, 7, 1, 0, 0, 0); // or x7,x2,x5
    @(negedge clock);
    checks += 3;
    if (op2_fwd !== 2'b10) begin errors++; $display("FAIL d2_op2 got %b want 10", op2_fwd); end
    if (op1_fwd !== 2'b00) begin errors++; $display("FAIL d2_op1 got %b want 00", op1_fwd); end
    if (block !== 1'b0) begin errors++; $display("FAIL d2_block got %b want 0", block); end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 1, 1, 0, 0, 8, 1, 1, 0, 0); // lw x8
    next_cycle();
    // dependent add held in decode; LSU answers on the third cycle
    for (int c = 0; c < 3; c++) begin
      drive(1, 8, 1, 8, 1, 9, 1, 0, c == 2, 0);
      @(negedge clock);
      checks++;
      if (block !== (c < 2)) begin errors++; $display("FAIL lu_block c%0d got %b want %b", c, block, c < 2); end
      if (c == 2) begin
        checks += 2;
        if (op1_fwd !== 2'b10) begin errors++; $display("FAIL lu_op1 got %b want 10", op1_fwd); end
        if (op2_fwd !== 2'b10) begin errors++; $display("FAIL lu_op2 got %b want 10", op2_fwd); end
      end
      next_cycle();
    end
    idle();
    checks++;
    if (hazard_stall_cnt !== 16'd2) begin errors++; $display("FAIL lu_cnt got %0d want 2", hazard_stall_cnt); end
  endtask

  task automatic test_x0();
    do_reset();
    drive(1, 1, 1, 2, 1, 0, 1, 0, 0, 0); // add x0
    next_cycle();
    drive(1, 0, 1, 0, 1, 1, 1, 0, 0, 0); // add x1,x0,x0
    @(negedge clock);
    checks += 3;
    if (op1_fwd !== 2'b00) begin errors++; $display("FAIL x0_op1 got %b want 00", op1_fwd); end
    if (op2_fwd !== 2'b00) begin errors++; $display("FAIL x0_op2 got %b want 00", op2_fwd); end
    if (block !== 1'b0) begin errors++; $display("FAIL x0_block got %b want 0", block); end
    next_cycle();
  endtask

  task automatic test_mispredict();
    do_reset();
    drive(1, 1, 1, 0, 0, 8, 1, 1, 0, 0); // lw x8
    next_cycle();
    drive(1, 8, 1, 0, 0, 9, 1, 0, 0, 0);
    next_cycle();                         // now waiting on the load
    drive(1, 8, 1, 0, 0, 9, 1, 0, 0, 1);
    @(negedge clock);
    checks++;
    if (block !== 1'b0) begin errors++; $display("FAIL mp_wp_block got %b want 0", block); end
    next_cycle();
    for (int c = 0; c < FC + 1; c++) begin
      drive(1, 8, 1, 8, 1, 9, 1, 0, 0, 0);
      @(negedge clock);
      checks += 2;
      if (clear_pipeline !== (c < FC)) begin errors++; $display("FAIL mp_clear c%0d got %b want %b", c, clear_pipeline, c < FC); end
      if (block !== 1'b0) begin errors++; $display("FAIL mp_block c%0d got %b want 0", c, block); end
      if (c == FC) begin
        checks += 2;
        if (op1_fwd !== 2'b00) begin errors++; $display("FAIL mp_op1 got %b want 00", op1_fwd); end
        if (op2_fwd !== 2'b00) begin errors++; $display("FAIL mp_op2 got %b want 00", op2_fwd); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    drive(1, 1, 1, 0, 0, 8, 1, 1, 0, 0);
    next_cycle();
    drive(1, 8, 1, 0, 0, 9, 1, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    next_cycle();
    idle();
    checks++;
    if (clear_pipeline !== 1'b1) begin errors++; $display("FAIL rmf_clear_pre got %b want 1", clear_pipeline); end
    #2 reset = 1'b0;
    #1;
    checks += 3;
    if (clear_pipeline !== 1'b0) begin errors++; $display("FAIL rmf_clear got %b want 0", clear_pipeline); end
    if (block !== 1'b0) begin errors++; $display("FAIL rmf_block got %b want 0", block); end
    if (hazard_stall_cnt !== 16'd0) begin errors++; $display("FAIL rmf_cnt got %0d want 0", hazard_stall_cnt); end
    @(negedge clock); reset = 1'b1;
    model_reset();
    next_cycle();
    drive(1, 1, 1, 0, 0, 8, 1, 1, 0, 0);
    @(negedge clock);
    checks++;
    if (clear_pipeline !== 1'b0) begin errors++; $display("FAIL rmf_clear_post got %b want 0", clear_pipeline); end
    next_cycle();
    drive(1, 8, 1, 0, 0, 9, 1, 0, 0, 0);
    @(negedge clock);
    checks++;
    if (block !== 1'b1) begin errors++; $display("FAIL rmf_run_stall got %b want 1", block); end
    next_cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(9) < 8, $urandom_range(3), $urandom_range(1), $urandom_range(3),
            $urandom_range(1), $urandom_range(3), $urandom_range(3) != 0, $urandom_range(2) == 0,
            $urandom_range(4) < 2, $urandom_range(29) == 0);
      @(negedge clock);
      checks += 5;
      if (block !== m_block()) begin errors++; $display("FAIL rnd_block n%0d got %b want %b", n, block, m_block()); end
      if (clear_pipeline !== (m_flush > 0)) begin errors++; $display("FAIL rnd_clear n%0d got %b want %b", n, clear_pipeline, m_flush > 0); end
      if (op1_fwd !== m_fwd(int'(id_rs1), id_rs1_used)) begin errors++; $display("FAIL rnd_op1 n%0d got %b want %b", n, op1_fwd, m_fwd(int'(id_rs1), id_rs1_used)); end
      if (op2_fwd !== m_fwd(int'(id_rs2), id_rs2_used)) begin errors++; $display("FAIL rnd_op2 n%0d got %b want %b", n, op2_fwd, m_fwd(int'(id_rs2), id_rs2_used)); end
      if (int'(hazard_stall_cnt) !== m_stall) begin errors++; $display("FAIL rnd_cnt n%0d got %0d want %0d", n, hazard_stall_cnt, m_stall); end
      @(posedge clock);
      model_step();
      #1;
    end
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_back_to_back();
    test_distance2();
    test_load_use();
    test_x0();
    test_mispredict();
    test_reset_mid_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/exu_hazard_ctrl.md
Name: exu_hazard_ctrl

Overview:
- Pipeline control unit for the execute stage.
- Tracks the two in-flight instructions downstream of decode: the EX slot and the MEM slot.
- From that tracking it generates the EXU stall (block), the operand forwarding selects (alu_operand1_sel / alu_operand2_sel forwarding bits) and the pipeline flush (clear_pipeline) after a wrong prediction.
- Sits between IDU, EXU and LSU; owns no datapath, only control.

Parameters:
- REG_AW, 5, register index width (x0..x31).
- FLUSH_CYCLES, 2, cycles clear_pipeline stays high per flush, range 1..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- decode_valid  in  1  IDU presents a decoded instruction.
- id_rs1  in  REG_AW  source register 1 index.
- id_rs2  in  REG_AW  source register 2 index.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  REG_AW  destination index.
- id_rd_wen  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- lsu_resp_valid  in  1  LSU returns load data (forward_data valid this cycle).
- is_wrong_prediction  in  1  from EXU, misprediction resolved.
- block  out  1  stall IDU/EXU register update.
- clear_pipeline  out  1  flush IFU/IDU/EXU.
- op1_fwd  out  2  bit0: use EXU result; bit1: use forward_data.
- op2_fwd  out  2  same encoding for rs2.
- hazard_stall_cnt  out  16  saturating count of stall cycles, for perf counters.

Behaviour:
- Slots are EX {v, rd, wen, ld} and MEM {v, rd, wen, ld}.
- On reset assertion, asynchronously:
  - all slot v=0, FSM=RUN, flush counter=0, hazard_stall_cnt=0;
  - outputs block=0, clear_pipeline=0, op1_fwd=op2_fwd=0.
- Match definitions:
  - A source "matches" a slot when the slot has v & wen, slot rd == src, src != 0, and used=1.
  - x0 never matches.
- Forwarding (combinational from slots and id_* inputs):
  - EX match, not ld: fwd = 2'b01. EX wins over MEM (youngest producer).
  - Else MEM match, not ld: fwd = 2'b10.
  - Else MEM match, ld, and lsu_resp_valid: fwd = 2'b10.
  - Otherwise 2'b00.
  - Never 2'b11.
- Load-use hazard (combinational):
  - EX match with ld=1, or MEM match with ld=1 while lsu_resp_valid=0.
- FSM states RUN, LOAD_WAIT, FLUSH:
  - RUN:
    - is_wrong_prediction=1 → FLUSH, highest priority.
    - Else a load-use hazard → block=1 and go to LOAD_WAIT.
    - Else block=0.
  - LOAD_WAIT:
    - block=1 until the hazard clears, then RUN with block=0 in the same cycle the hazard clears.
    - is_wrong_prediction still has priority → FLUSH.
  - FLUSH:
    - clear_pipeline=1 and block=0 for exactly FLUSH_CYCLES cycles.
    - Both slots are invalidated on entry.
    - decode_valid is ignored during FLUSH.
    - Then → RUN.
  - is_wrong_prediction while already in FLUSH restarts the counter.
- Slot advance on each clock edge when not in FLUSH:
  - If block=0: MEM ← EX, EX ← {decode_valid, id_rd, id_rd_wen, id_is_load}.
  - If block=1: EX holds.
    - If MEM is a non-load, it retires (MEM ← EX, EX.v ← 0).
    - If MEM is a load, it retires only when lsu_resp_valid=1.
  - Simultaneous advance and retire: advance wins, because MEM is overwritten by EX.
- hazard_stall_cnt increments every cycle block=1 and saturates at 16'hFFFF.
- Reset deassertion mid-operation resumes in RUN with empty slots.

Test Plan:
1. Back-to-back ALU dependency: add x5 then sub x6,x5,x1 → op1_fwd=2'b01 on the second instruction; block never asserted.
2. Distance-2 dependency: add x5; nop; or x7,x2,x5 → op2_fwd=2'b10; block=0.
3. Load-use, LSU latency 3 cycles: lw x8 then add x9,x8,x8:
   - block=1 for exactly the cycles until lsu_resp_valid;
   - in the response cycle op1_fwd=op2_fwd=2'b10 and block=0;
   - hazard_stall_cnt equals the stall count.
4. x0 destination: add x0 then add x1,x0,x0 → op1_fwd=op2_fwd=2'b00; no stall.
5. Misprediction during LOAD_WAIT:
   - clear_pipeline high exactly 2 cycles (FLUSH_CYCLES=2) and block=0;
   - both slots cleared, so the next instruction reading x8 gets fwd=2'b00.
6. Async reset pulse mid-FLUSH → clear_pipeline and block drop immediately; after release the FSM is in RUN and the counter is 0.
